uart_bus_bridge: RTL and testbench

//  Host-side initiator for the UART peripheral register bus (ren/we/addr/wdata/rdata).

---
 rtl/uart_bridge_pkg.sv | 24 ++
 rtl/uart_bus_bridge.sv | 155 +++++++++++++++
 tb/tb_uart_bus_bridge.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encodings for the UART-to-register-bus bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StBusWr,
    StBusRd,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    RspAck,
    RspErr,
    RspData
  } resp_e;

endpackage

// File: rtl/uart_bus_bridge.sv
// Byte-command parser that turns UART frames into single-beat register-bus reads/writes
// and streams the acknowledge or read data back to a UART transmitter.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_W           = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        ren,
  output logic        we,
  output logic [7:0]  addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        err_o
);

  localparam logic [TO_W-1:0] ToMax = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  resp_e           resp_q, resp_d;
  logic            is_wr_q, is_wr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  logic            last_byte;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      resp_q  <= RspAck;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // cnt_q indexes wdata bytes while parsing and response bytes while transmitting
  assign last_byte = (resp_q != RspData) || (cnt_q == 2'd3);

  always_comb begin
    state_d  = state_q;
    resp_d   = resp_q;
    is_wr_d  = is_wr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    to_d     = to_q;
    err_d    = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = '0;
    we       = 1'b0;
    ren      = 1'b0;
    unique case (state_q)
      StIdle: begin
        to_d  = '0;
        cnt_d = '0;
        if (rx_valid) begin
          if (rx_byte == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = StAddr;
          end else if (rx_byte == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = StAddr;
          end else begin
            resp_d  = RspErr;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StAddr, StWdata: begin
        // A byte arriving in the expiry cycle takes priority over the timeout
        if (rx_valid) begin
          to_d = '0;
          if (state_q == StAddr) begin
            addr_d  = rx_byte;
            cnt_d   = '0;
            state_d = is_wr_q ? StWdata : StBusRd;
          end else begin
            wdata_d[{cnt_q, 3'b000} +: 8] = rx_byte;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = StBusWr;
          end
        end else if (to_q == ToMax) begin
          to_d    = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StBusWr: begin
        we      = 1'b1;
        err_d   = rx_valid;
        resp_d  = RspAck;
        cnt_d   = '0;
        state_d = StResp;
      end
      StBusRd: begin
        ren     = 1'b1;
        err_d   = rx_valid;
        rdata_d = rdata;
        resp_d  = RspData;
        cnt_d   = '0;
        state_d = StResp;
      end
      StResp: begin
        tx_valid = 1'b1;
        err_d    = rx_valid;
        unique case (resp_q)
          RspAck:  tx_byte = RSP_ACK;
          RspErr:  tx_byte = RSP_ERR;
          default: tx_byte = rdata_q[{cnt_q, 3'b000} +: 8];
        endcase
        if (tx_ready) begin
          if (last_byte) state_d = StIdle;
          else           cnt_d   = cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign busy  = (state_q != StIdle);
  assign err_o = err_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: table of complete frames plus hand-written
// sequences for backpressure, dropped bytes, timeout and asynchronous reset.
module tb_uart_bus_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        ren;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        err_o;

  uart_bus_bridge #(
    .TIMEOUT_CYCLES(16),
    .TO_W          (5)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .tx_byte (tx_byte),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ren     (ren),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Register responder: fixed pattern, with a distinctive word at address 0
  always_comb rdata = (addr == 8'h00) ? 32'hCAFEF00D : {addr, 8'h11, 8'h22, 8'h33};

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int ren_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  logic [7:0] tx_q[$];

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (we) we_cnt++;
      if (ren) ren_cnt++;
      if (err_o) err_cnt++;
      if (we && ren) overlap_cnt++;
      if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_i);
    #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk_i);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] tx_at(input int idx);
    if (idx < tx_q.size()) return {24'd0, tx_q[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  typedef struct {
    string       name;
    logic [7:0]  b [6];
    int          n;
    bit          lat;
    int          we_n;
    int          ren_n;
    int          err_n;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          ntx;
    logic [7:0]  tx [4];
  } vec_t;

  vec_t vecs[5];

  initial begin
    int we0, ren0, err0, tx0;
    bit stable;
    logic [7:0] exp_rd [4];

    vecs[0] = '{"wr04", '{8'h57, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12}, 6, 1'b1, 1, 0, 0,
                8'h04, 32'h12345678, 1, '{8'h4B, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{"rd00", '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b1, 0, 1, 0,
                8'h00, 32'h12345678, 4, '{8'h0D, 8'hF0, 8'hFE, 8'hCA}};
    vecs[2] = '{"bad33", '{8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 0, 0, 1,
                8'h00, 32'h12345678, 1, '{8'h45, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{"wr10", '{8'h57, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04}, 6, 1'b1, 1, 0, 0,
                8'h10, 32'h04030201, 1, '{8'h4B, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{"rd10", '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b1, 0, 1, 0,
                8'h10, 32'h04030201, 4, '{8'h33, 8'h22, 8'h11, 8'h10}};

    rst_i    = 1'b1;
    rx_byte  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    #12;
    check("rst_outs", {11'd0, tx_valid, tx_byte, ren, we, addr, busy, err_o}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    tx_ready = 1'b1;

    // Table-driven frames with tx_ready held high
    for (int v = 0; v < 5; v++) begin
      we0 = we_cnt; ren0 = ren_cnt; err0 = err_cnt; tx0 = tx_q.size();
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k]);
      check({vecs[v].name, "_we_n1"}, {31'd0, we}, {31'd0, vecs[v].we_n == 1});
      check({vecs[v].name, "_ren_n1"}, {31'd0, ren}, {31'd0, vecs[v].ren_n == 1});
      if (vecs[v].lat) begin
        check({vecs[v].name, "_txv_n1"}, {31'd0, tx_valid}, 32'd0);
        @(posedge clk_i);
        #1;
        check({vecs[v].name, "_txv_n2"}, {31'd0, tx_valid}, 32'd1);
        check({vecs[v].name, "_tx0_n2"}, {24'd0, tx_byte}, {24'd0, vecs[v].tx[0]});
      end
      wait_idle(vecs[v].name);
      check({vecs[v].name, "_we_cnt"}, we_cnt - we0, vecs[v].we_n);
      check({vecs[v].name, "_ren_cnt"}, ren_cnt - ren0, vecs[v].ren_n);
      check({vecs[v].name, "_err_cnt"}, err_cnt - err0, vecs[v].err_n);
      check({vecs[v].name, "_addr"}, {24'd0, addr}, {24'd0, vecs[v].addr});
      check({vecs[v].name, "_wdata"}, wdata, vecs[v].wdata);
      check({vecs[v].name, "_ntx"}, tx_q.size() - tx0, vecs[v].ntx);
      for (int k = 0; k < vecs[v].ntx; k++)
        check({vecs[v].name, "_tx"}, tx_at(tx0 + k), {24'd0, vecs[v].tx[k]});
    end

    // Backpressure: each read byte held stable for 10 cycles, then sent once
    exp_rd = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    tx_ready = 1'b0;
    tx0 = tx_q.size();
    send_byte(8'h52);
    send_byte(8'h00);
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 4; k++) begin
      stable = 1'b1;
      repeat (10) begin
        @(negedge clk_i);
        if (!tx_valid || tx_byte !== exp_rd[k]) stable = 1'b0;
      end
      check("bp_stable", {31'd0, stable}, 32'd1);
      @(posedge clk_i);
      #1;
      tx_ready = 1'b1;
      @(posedge clk_i);
      #1;
      tx_ready = 1'b0;
    end
    wait_idle("bp");
    check("bp_ntx", tx_q.size() - tx0, 4);
    for (int k = 0; k < 4; k++) check("bp_tx", tx_at(tx0 + k), {24'd0, exp_rd[k]});

    // Byte arriving during a response is dropped with an error pulse
    we0 = we_cnt; ren0 = ren_cnt; err0 = err_cnt; tx0 = tx_q.size();
    send_byte(8'h33);
    send_byte(8'h52);
    repeat (3) @(negedge clk_i);
    check("drop_busy", {31'd0, busy}, 32'd1);
    check("drop_txb", {24'd0, tx_byte}, 32'h45);
    tx_ready = 1'b1;
    wait_idle("drop");
    check("drop_err", err_cnt - err0, 2);
    check("drop_ren", ren_cnt - ren0, 0);
    check("drop_we", we_cnt - we0, 0);
    check("drop_ntx", tx_q.size() - tx0, 1);
    check("drop_tx", tx_at(tx0), 32'h45);

    // Timeout after 16 idle cycles mid-frame
    we0 = we_cnt; err0 = err_cnt; tx0 = tx_q.size();
    send_byte(8'h57);
    send_byte(8'h04);
    repeat (15) @(posedge clk_i);
    #1;
    check("to_busy15", {30'd0, busy, err_o}, 32'b10);
    @(posedge clk_i);
    #1;
    check("to_expire", {30'd0, busy, err_o}, 32'b01);
    @(posedge clk_i);
    #1;
    check("to_errpulse", {31'd0, err_o}, 32'd0);
    check("to_err_cnt", err_cnt - err0, 1);
    check("to_no_we", we_cnt - we0, 0);
    check("to_no_tx", tx_q.size() - tx0, 0);

    // A byte landing exactly on the expiry edge is consumed instead
    we0 = we_cnt; err0 = err_cnt; tx0 = tx_q.size();
    send_byte(8'h57);
    send_byte(8'h04);
    repeat (14) @(posedge clk_i);
    send_byte(8'h11);
    check("to_edge_busy", {30'd0, busy, err_o}, 32'b10);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_idle("to_edge");
    check("to_edge_we", we_cnt - we0, 1);
    check("to_edge_err", err_cnt - err0, 0);
    check("to_edge_wdata", wdata, 32'h44332211);
    check("to_edge_tx", tx_at(tx0), 32'h4B);

    // Asynchronous reset while wdata byte 2 is arriving
    send_byte(8'h57);
    send_byte(8'h04);
    send_byte(8'hAA);
    @(posedge clk_i);
    #1;
    rx_valid = 1'b1;
    rx_byte  = 8'hBB;
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_outs", {11'd0, tx_valid, tx_byte, ren, we, addr, busy, err_o}, 32'd0);
    check("arst_wdata", wdata, 32'd0);
    rx_valid = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    we0 = we_cnt; tx0 = tx_q.size();
    send_byte(8'h57);
    send_byte(8'h20);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    wait_idle("arst_wr");
    check("arst_we", we_cnt - we0, 1);
    check("arst_addr", {24'd0, addr}, 32'h20);
    check("arst_wdata2", wdata, 32'hDEADBEEF);
    check("arst_tx", tx_at(tx0), 32'h4B);

    check("we_ren_overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
